// File: rtl/pipe_cpu_pkg.sv
// Shared types for the pipelined CPU memory path.
// FSM states, access owner and the minimum access latency.
package pipe_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        DM_BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } arb_owner_t;

    // Cycles from grant to port ack with a zero-wait memory.
    localparam int unsigned ARB_MIN_LAT = 2;

endpackage

// File: rtl/unified_mem_arbiter_starve_cnt.sv
// Counts consecutive data grants taken while a fetch is waiting.
// Saturates at STARVE_MAX; limit_o tells the arbiter to let IF in.
module arb_starve_cnt
    import pipe_cpu_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic limit_o
);

    localparam int unsigned CW =
        (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over increment; hold once the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign limit_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Define ARB_FAIRNESS_EN to bound how long a fetch can be starved by data.
module unified_mem_arbiter
    import pipe_cpu_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              stall_if_o,
    output logic              stall_mem_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              err_o
);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              err_q, err_d;

    logic busy;
    logic grant_if;
    logic grant_dm;
    logic starve_lim;

    assign busy = (state_q == IF_BUSY) || (state_q == DM_BUSY);

`ifdef ARB_FAIRNESS_EN
    arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (grant_if | ~if_req_i),
        .inc_i   (grant_dm & if_req_i),
        .limit_o (starve_lim)
    );
`else
    logic unused_starve;
    assign unused_starve = (STARVE_MAX == 0);
    assign starve_lim    = 1'b0;
`endif

    // Only IDLE arbitrates: data first, unless fetch has waited too long.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state_q == IDLE) begin
            if (dm_req_i && !(if_req_i && starve_lim)) begin
                grant_dm = 1'b1;
            end else if (if_req_i) begin
                grant_if = 1'b1;
            end
        end
    end

    // Next state: latch the winner, wait for memory, report for one cycle.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d = DM_BUSY;
                    owner_d = OWN_DM;
                    we_d    = dm_we_i;
                    addr_d  = dm_addr_i;
                    wdata_d = dm_wdata_i;
                end else if (grant_if) begin
                    state_d = IF_BUSY;
                    owner_d = OWN_IF;
                    we_d    = 1'b0;
                    addr_d  = if_addr_i;
                    wdata_d = '0;
                end
            end
            IF_BUSY: begin
                if (mem_ack_i) begin
                    if_rdata_d = mem_rdata_i;
                    state_d    = RESP;
                end
            end
            DM_BUSY: begin
                if (mem_ack_i) begin
                    if (!we_q) begin
                        dm_rdata_d = mem_rdata_i;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (mem_ack_i && !busy) begin
            err_d = 1'b1;
        end
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            err_q      <= err_d;
        end
    end

    assign mem_req_o   = busy;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    assign if_ack_o    = (state_q == RESP) && (owner_q == OWN_IF);
    assign dm_ack_o    = (state_q == RESP) && (owner_q == OWN_DM);
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;

    assign stall_if_o  = if_req_i & ~if_ack_o;
    assign stall_mem_o = dm_req_i & ~dm_ack_o;

    assign err_o       = err_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter.
// Transaction-level model plus directed scenarios; honours ARB_FAIRNESS_EN.
module tb_unified_mem_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        stall_if_o;
    logic        stall_mem_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        err_o;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ack_o    (if_ack_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ack_o    (dm_ack_o),
        .stall_if_o  (stall_if_o),
        .stall_mem_o (stall_mem_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .err_o       (err_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Memory contents; unwritten words return an address-derived pattern.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Model: m_own = access holding memory (0 none, 1 IF, 2 DM),
    // m_done = port whose completion is reported this cycle.
    int          m_own = 0;
    int          m_done = 0;
    int          m_cnt = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic        m_we = 1'b0;
    logic [31:0] m_if_rd = '0;
    logic [31:0] m_dm_rd = '0;
    logic        m_err = 1'b0;

    always @(posedge clk or negedge rst_i) begin
        bit pick_if;
        if (!rst_i) begin
            m_own = 0; m_done = 0; m_cnt = 0;
            m_addr = '0; m_wdata = '0; m_we = 1'b0;
            m_if_rd = '0; m_dm_rd = '0; m_err = 1'b0;
        end else begin
            if (mem_ack_i && m_own == 0) m_err = 1'b1;
            if (m_own != 0) begin
                if (mem_ack_i) begin
                    if (m_own == 1) m_if_rd = mem_rdata_i;
                    else if (!m_we) m_dm_rd = mem_rdata_i;
                    m_done = m_own;
                    m_own = 0;
                end
            end else if (m_done != 0) begin
                m_done = 0;
            end else begin
                pick_if = if_req_i && (!dm_req_i || m_cnt >= SMAX);
                if (pick_if) begin
                    m_own = 1; m_addr = if_addr_i;
                    m_we = 1'b0; m_wdata = '0;
                    m_cnt = 0;
                end else if (dm_req_i) begin
                    m_own = 2; m_addr = dm_addr_i;
                    m_we = dm_we_i; m_wdata = dm_wdata_i;
`ifdef ARB_FAIRNESS_EN
                    if (if_req_i && m_cnt < SMAX) m_cnt++;
`endif
                end
            end
`ifdef ARB_FAIRNESS_EN
            if (!if_req_i) m_cnt = 0;
`endif
        end
    end

    // Compare every output against the model away from the clock edge.
    always @(negedge clk) begin
        chk("mem_req", mem_req_o, m_own != 0);
        chk("mem_addr", mem_addr_o, m_addr);
        chk("mem_we", mem_we_o, m_we);
        chk("mem_wdata", mem_wdata_o, m_wdata);
        chk("if_ack", if_ack_o, m_done == 1);
        chk("dm_ack", dm_ack_o, m_done == 2);
        chk("if_rdata", if_rdata_o, m_if_rd);
        chk("dm_rdata", dm_rdata_o, m_dm_rd);
        chk("stall_if", stall_if_o, if_req_i && m_done != 1);
        chk("stall_mem", stall_mem_o, dm_req_i && m_done != 2);
        chk("err", err_o, m_err);
        chk("ack_excl", if_ack_o & dm_ack_o, 1'b0);
    end

    bit rnd_en = 0;
    bit spur = 0;
    bit rsp_done = 0;
    int fw = 0;
    int rsp_wait = 0;

    // One clock: memory responder, then random requesters if enabled.
    task automatic step();
        logic a_if, a_dm;
        @(negedge clk);
        a_if = if_ack_o;
        a_dm = dm_ack_o;
        @(posedge clk);
        #1;
        if (spur) begin
            mem_ack_i = 1'b1;
            spur = 0;
        end else if (mem_req_o && !rsp_done) begin
            if (rsp_wait == 0) begin
                mem_ack_i = 1'b1;
                if (mem_we_o) begin
                    mem[mem_addr_o] = mem_wdata_o;
                    mem_rdata_i = $urandom;
                end else begin
                    mem_rdata_i = rd(mem_addr_o);
                end
                rsp_done = 1;
            end else begin
                mem_ack_i = 1'b0;
                rsp_wait--;
            end
        end else begin
            mem_ack_i = 1'b0;
            mem_rdata_i = $urandom;
            if (!mem_req_o) begin
                rsp_done = 0;
                rsp_wait = (fw < 0) ? $urandom_range(0, 3) : fw;
            end
        end
        if (rnd_en) begin
            if (if_req_i) begin
                if (a_if) begin
                    if_req_i = ($urandom_range(0, 99) < 40);
                    if_addr_i = 32'($urandom_range(0, 63)) << 2;
                end else if ($urandom_range(0, 99) < 2) begin
                    if_req_i = 1'b0;
                end
            end else if ($urandom_range(0, 99) < 30) begin
                if_req_i = 1'b1;
                if_addr_i = 32'($urandom_range(0, 63)) << 2;
            end
            if (dm_req_i && !a_dm) begin
                if ($urandom_range(0, 99) < 2) dm_req_i = 1'b0;
            end else if (a_dm || $urandom_range(0, 99) < 30) begin
                dm_req_i = (a_dm) ? ($urandom_range(0, 99) < 40) : 1'b1;
                dm_we_i = $urandom_range(0, 1);
                dm_addr_i = 32'($urandom_range(0, 63)) << 2;
                dm_wdata_i = $urandom;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int n;
        bit got;
        bit gi [10];

        // Reset state; stall follows request even in reset.
        if_req_i = 1'b1;
        idle(3);
        #1;
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_acks", {if_ack_o, dm_ack_o}, 2'b00);
        chk("rst_err", err_o, 1'b0);
        chk("rst_rdata", if_rdata_o | dm_rdata_o, 32'h0);
        chk("rst_stall_if", stall_if_o, 1'b1);
        if_req_i = 1'b0;
        rst_i = 1'b1;
        fw = 0;
        idle(2);

        // Fetch alone, zero wait: ack on the third cycle.
        mem[32'h10] = 32'h0013_0093;
        if_addr_i = 32'h10;
        if_req_i = 1'b1;
        #1;
        chk("t1_stall_c1", stall_if_o, 1'b1);
        chk("t1_ack_c1", if_ack_o, 1'b0);
        step(); #1;
        chk("t1_req_c2", mem_req_o, 1'b1);
        chk("t1_addr_c2", mem_addr_o, 32'h10);
        chk("t1_stall_c2", stall_if_o, 1'b1);
        step(); #1;
        chk("t1_ack_c3", if_ack_o, 1'b1);
        chk("t1_rdata", if_rdata_o, 32'h0013_0093);
        chk("t1_stall_c3", stall_if_o, 1'b0);
        if_req_i = 1'b0;
        step(); #1;
        chk("t1_ack_once", if_ack_o, 1'b0);
        idle(2);

        // Both at once: store goes first, then the fetch.
        mem[32'h20] = 32'h1111_2222;
        dm_req_i = 1'b1; dm_we_i = 1'b1;
        dm_addr_i = 32'h40; dm_wdata_i = 32'hDEAD_BEEF;
        if_req_i = 1'b1; if_addr_i = 32'h20;
        step(); #1;
        chk("t2_we", mem_we_o, 1'b1);
        chk("t2_addr", mem_addr_o, 32'h40);
        chk("t2_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        step(); #1;
        chk("t2_dm_ack", {dm_ack_o, if_ack_o}, 2'b10);
        dm_req_i = 1'b0;
        step(); #1;
        chk("t2_idle", mem_req_o, 1'b0);
        step(); #1;
        chk("t2_if_addr", mem_addr_o, 32'h20);
        chk("t2_if_we", mem_we_o, 1'b0);
        step(); #1;
        chk("t2_if_ack", {dm_ack_o, if_ack_o}, 2'b01);
        chk("t2_if_rdata", if_rdata_o, 32'h1111_2222);
        if_req_i = 1'b0;
        fw = 3;
        idle(2);

        // Load with three wait cycles.
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step(); #1;
            if (!mem_req_o) break;
            n++;
            chk("t3_addr_stable", mem_addr_o, 32'h40);
            chk("t3_we_stable", mem_we_o, 1'b0);
        end
        chk("t3_req_cycles", n, 4);
        chk("t3_dm_ack", dm_ack_o, 1'b1);
        chk("t3_rdata", dm_rdata_o, 32'hDEAD_BEEF);
        dm_req_i = 1'b0;
        idle(2);

        // Reset during a store; the store is retried afterwards.
        dm_req_i = 1'b1; dm_we_i = 1'b1;
        dm_addr_i = 32'h80; dm_wdata_i = 32'h1234_5678;
        step(); #1;
        chk("t4_busy", mem_req_o, 1'b1);
        rst_i = 1'b0;
        #1;
        chk("t4_req_drop", mem_req_o, 1'b0);
        chk("t4_no_ack", dm_ack_o, 1'b0);
        chk("t4_no_write", mem.exists(32'h80), 1'b0);
        step();
        rst_i = 1'b1;
        step(); #1;
        chk("t4_retry_req", mem_req_o, 1'b1);
        chk("t4_retry_we", mem_we_o, 1'b1);
        chk("t4_retry_addr", mem_addr_o, 32'h80);
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            step(); #1;
            got = dm_ack_o;
        end
        chk("t4_ack_seen", got, 1'b1);
        chk("t4_stored", rd(32'h80), 32'h1234_5678);
        dm_req_i = 1'b0;
        fw = 0;
        idle(3);

        // Both held: grant order shows whether fairness is built in.
        if_req_i = 1'b1; if_addr_i = 32'h10;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40;
        n = 0;
        for (int k = 0; k < 80 && n < 10; k++) begin
            step(); #1;
            if (if_ack_o || dm_ack_o) begin
                gi[n] = if_ack_o;
                n++;
            end
        end
        chk("t6_grants", n, 10);
        for (int i = 0; i < 10; i++) begin
`ifdef ARB_FAIRNESS_EN
            chk($sformatf("t6_grant%0d", i), gi[i], (i % 5) == 4);
`else
            chk($sformatf("t6_grant%0d", i), gi[i], 1'b0);
`endif
        end
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
        idle(8);

        // Random traffic against the model.
        fw = -1;
        rnd_en = 1;
        idle(3000);
        rnd_en = 0;
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
        idle(15);

        // Stray memory ack while idle: sticky error until reset.
        chk("t5_err_pre", err_o, 1'b0);
        spur = 1;
        step(); #1;
        chk("t5_ack_idle", mem_ack_i, 1'b1);
        step(); #1;
        chk("t5_err_set", err_o, 1'b1);
        chk("t5_no_port_ack", {if_ack_o, dm_ack_o}, 2'b00);
        idle(3); #1;
        chk("t5_err_sticky", err_o, 1'b1);
        rst_i = 1'b0;
        #1;
        chk("t5_err_clr", err_o, 1'b0);
        step();
        rst_i = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
